fiber_stream_sink: RTL

FIBER_STREAM_SINK -- requirements
Module: fiber_stream_sink

---
 rtl/fiber_stream_sink.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fiber_stream_sink.sv
// Stream sink: accepts tokens under a selectable backpressure pattern,
// classifies them (data / stop / done), captures the first DEPTH non-done
// tokens and keeps saturating statistics until a done token ends the stream.
module fiber_stream_sink #(
    parameter int          DATA_WIDTH = 17,
    parameter int          DEPTH      = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     tile_en,
    input  logic [1:0]               stall_mode,
    input  logic [7:0]               gap_cycles,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]   capture_count,
    output logic [15:0]              data_count,
    output logic [15:0]              stop_count,
    output logic [31:0]              cycle_count,
    output logic                     overflow,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] DONE_TOK = DATA_WIDTH'(17'h10100);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [7:0]            gap_q, gap_d;
    logic [AW:0]           cap_cnt_q, cap_cnt_d;
    logic [15:0]           data_cnt_q, data_cnt_d;
    logic [15:0]           stop_cnt_q, stop_cnt_d;
    logic [31:0]           cyc_cnt_q, cyc_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  cap_we;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic hs, tok_done, tok_stop, cap_full;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting toward the MSB
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign tok_done = (data_in == DONE_TOK);
    assign tok_stop = data_in[16] & ~tok_done;
    assign hs       = data_in_valid & data_in_ready;
    // DEPTH is a power of two, so the count MSB alone marks a full buffer
    assign cap_full = cap_cnt_q[AW];

    // Ready is built from registered state and control inputs only, never from valid
    always_comb begin
        data_in_ready = 1'b0;
        if (!rst && tile_en && !flush && state_q != S_DONE) begin
            case (stall_mode)
                2'd1:    data_in_ready = lfsr_q[0];
                2'd2:    data_in_ready = (gap_q == 8'd0);
                default: data_in_ready = 1'b1;
            endcase
        end
    end

    // Next-state for the FSM, backpressure generators, counters and capture pointer
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        gap_d      = gap_q;
        cap_cnt_d  = cap_cnt_q;
        data_cnt_d = data_cnt_q;
        stop_cnt_d = stop_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        ovf_d      = ovf_q;
        cap_we     = 1'b0;
        if (flush) begin
            // flush wins over everything, including a token on the same edge
            state_d    = S_IDLE;
            lfsr_d     = LFSR_SEED;
            gap_d      = 8'd0;
            cap_cnt_d  = '0;
            data_cnt_d = 16'd0;
            stop_cnt_d = 16'd0;
            cyc_cnt_d  = 32'd0;
            ovf_d      = 1'b0;
        end else begin
            if (tile_en) lfsr_d = lfsr_step(lfsr_q);
            if (hs && stall_mode == 2'd2) gap_d = gap_cycles;
            else if (gap_q != 8'd0)       gap_d = gap_q - 8'd1;
            case (state_q)
                S_IDLE:  if (hs) state_d = tok_done ? S_DONE : S_RECV;
                S_RECV:  if (hs && tok_done) state_d = S_DONE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
            // the first-token cycle and the done-handshake cycle both count as receiving
            if (state_q == S_RECV || state_d == S_RECV) cyc_cnt_d = sat_inc32(cyc_cnt_q);
            if (hs && !tok_done) begin
                if (tok_stop) stop_cnt_d = sat_inc16(stop_cnt_q);
                else          data_cnt_d = sat_inc16(data_cnt_q);
                if (cap_full) begin
                    ovf_d = 1'b1;
                end else begin
                    cap_we    = 1'b1;
                    cap_cnt_d = cap_cnt_q + 1'b1;
                end
            end
        end
    end

    // Control and statistics registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            gap_q      <= 8'd0;
            cap_cnt_q  <= '0;
            data_cnt_q <= 16'd0;
            stop_cnt_q <= 16'd0;
            cyc_cnt_q  <= 32'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            gap_q      <= gap_d;
            cap_cnt_q  <= cap_cnt_d;
            data_cnt_q <= data_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Capture storage is plain data and is never cleared
    always_ff @(posedge clk) begin
        if (cap_we) mem[cap_cnt_q[AW-1:0]] <= data_in;
    end

    assign rd_data       = mem[rd_addr];
    assign capture_count = cap_cnt_q;
    assign data_count    = data_cnt_q;
    assign stop_count    = stop_cnt_q;
    assign cycle_count   = cyc_cnt_q;
    assign overflow      = ovf_q;
    assign done          = (state_q == S_DONE);

endmodule
